// File: rtl/mcu_in_port_collector_if.sv
// mcu_in_port_collector_if: MCU input-port bus between the MCU (master) and the collector (slave)
// port_id : MCU port address
// in_strb : one-cycle pulse while the MCU executes IN on port_id
// in_port : read data returned to the MCU
// irq     : registered pending-data interrupt request
interface mcu_in_port_collector_if;
  logic [7:0] port_id;
  logic       in_strb;
  logic [7:0] in_port;
  logic       irq;
  modport master (output port_id, in_strb, input in_port, irq);
  modport slave  (input port_id, in_strb, output in_port, irq);
endinterface

// File: rtl/mcu_in_port_collector.sv
// mcu_in_port_collector: captures bytes from four async peripherals and holds them for MCU reads
// clk, rst          : rising-edge clock, asynchronous active-high reset
// dev_data_0..3     : peripheral bytes, stable from dev_vld rise until capture
// dev_vld_0..3      : asynchronous valid levels, rising edge marks a new byte
// bus (slave)       : port_id/in_strb in, in_port (combinational) and irq (registered) out
// BASE_ID+0..3 read held bytes, BASE_ID+4 reads {ovr, flag}; IN strobe on an ID clears it.
// Optional macro OVR_COUNT_EN adds a saturating overrun counter at BASE_ID+5.
module mcu_in_port_collector #(
  parameter logic [7:0] BASE_ID     = 8'h20,
  parameter int         SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      rst,
  input logic [7:0]                dev_data_0,
  input logic [7:0]                dev_data_1,
  input logic [7:0]                dev_data_2,
  input logic [7:0]                dev_data_3,
  input logic                      dev_vld_0,
  input logic                      dev_vld_1,
  input logic                      dev_vld_2,
  input logic                      dev_vld_3,
  mcu_in_port_collector_if.slave   bus
);
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic [3:0][7:0] data, hold;
  logic [3:0] vld, prev, cap, flag, ovr, clr, ovr_ev;
  logic [7:0] off, ext_rd;
  logic stat_clr;
  assign data = {dev_data_3, dev_data_2, dev_data_1, dev_data_0};
  assign vld = {dev_vld_3, dev_vld_2, dev_vld_1, dev_vld_0};
  assign off = bus.port_id - BASE_ID;
  assign cap = sync[SYNC_STAGES-1] & ~prev;
  assign ovr_ev = cap & flag;
  assign clr = (bus.in_strb && off < 8'd4) ? 4'(4'b1 << off[1:0]) : 4'b0;
  assign stat_clr = bus.in_strb && off == 8'd4;
  // a capture on the same edge as a data-read clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= '0;
      hold <= '0;
      flag <= '0;
      ovr <= '0;
      bus.irq <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], vld};
      prev <= sync[SYNC_STAGES-1];
      for (int i = 0; i < 4; i++) if (cap[i]) hold[i] <= data[i];
      flag <= cap | (flag & ~clr);
      ovr <= ovr_ev | (stat_clr ? 4'b0 : ovr);
      bus.irq <= |flag;
    end
  end
`ifdef OVR_COUNT_EN
  logic [7:0] ovr_cnt;
  logic [2:0] inc;
  logic [8:0] sum;
  assign inc = 3'(ovr_ev[0]) + 3'(ovr_ev[1]) + 3'(ovr_ev[2]) + 3'(ovr_ev[3]);
  assign sum = {1'b0, ovr_cnt} + {6'b0, inc};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_cnt <= '0;
    else ovr_cnt <= (bus.in_strb && off == 8'd5) ? {5'b0, inc} : (sum[8] ? 8'hFF : sum[7:0]);
  end
  assign ext_rd = off == 8'd5 ? ovr_cnt : 8'h00;
`else
  assign ext_rd = 8'h00;
`endif
  assign bus.in_port = off < 8'd4 ? hold[off[1:0]] : off == 8'd4 ? {ovr, flag} : ext_rd;
endmodule
